// File: rtl/arb_pkg.sv
// Shared arbiter definitions: mode encodings and default channel count.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/pri_search.sv
// Rotated descending priority search: start, start-1, ..., 0, N-1, ..., start+1.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is captured.
module pri_search #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    int pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            // Wrap below zero back to the top channel.
            pos = (int'(start) - k + N) % N;
            if (!found && req[pos[W-1:0]]) begin
                found = 1'b1;
                idx   = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Fixed-priority / round-robin arbiter with registered grant outputs.
// Latency: one cycle from sampled req to presented grant; back-to-back on ack.
// Backpressure: a presented grant holds until ack; req changes are ignored meanwhile.
module priority_arbiter_rr
    import arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_oh,
    output logic         valid
);

    localparam logic [W-1:0] TOP_IDX = W'(N - 1);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;
    logic [W-1:0] search_start;
    logic [W-1:0] search_idx;
    logic         search_found;
    logic         accept;
    logic         load;

    assign accept = valid & ack;
    assign load   = ~valid | ack;

    // The search after an accept must already see the advanced pointer,
    // otherwise round-robin would re-grant the same channel once.
    always_comb begin
        ptr_nxt = ptr;
        if (accept) begin
            ptr_nxt = (grant_idx == '0) ? TOP_IDX : grant_idx - W'(1);
        end
    end

    // Fixed priority is the rotated search pinned at the top channel.
    assign search_start = (mode == MODE_RR) ? ptr_nxt : TOP_IDX;

    pri_search #(
        .N (N),
        .W (W)
    ) u_pri_search (
        .req   (req),
        .start (search_start),
        .idx   (search_idx),
        .found (search_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= TOP_IDX;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            grant_idx <= '0;
            grant_oh  <= '0;
        end else if (load) begin
            valid     <= search_found;
            grant_idx <= search_found ? search_idx : '0;
            grant_oh  <= search_found ? (N'(1) << search_idx) : '0;
        end
    end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr (N=4) with hand-computed expectations.
module tb_priority_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       mode;
    logic       ack;
    logic [1:0] grant_idx;
    logic [3:0] grant_oh;
    logic       valid;

    int n_checks = 0;
    int n_pass   = 0;

    priority_arbiter_rr #(.N(4), .W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .ack       (ack),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks valid/idx/oh together; oh is derived from the expected index.
    task automatic chk_grant(input string tag, input bit exp_vld, input int exp_idx);
        int exp_oh;
        exp_oh = exp_vld ? (1 << exp_idx) : 0;
        chk({tag, ".valid"}, int'(valid), int'(exp_vld));
        chk({tag, ".idx"},   int'(grant_idx), exp_vld ? exp_idx : 0);
        chk({tag, ".oh"},    int'(grant_oh), exp_oh);
    endtask

    typedef struct {
        logic [3:0] r;
        bit         v;
        int         i;
    } vec_t;

    vec_t fixed_tbl[6];
    int   rr_seq[8];
    int   sparse_seq[4];

    initial begin
        fixed_tbl[0] = '{4'b0000, 1'b0, 0};
        fixed_tbl[1] = '{4'b1000, 1'b1, 3};
        fixed_tbl[2] = '{4'b0100, 1'b1, 2};
        fixed_tbl[3] = '{4'b0110, 1'b1, 2};
        fixed_tbl[4] = '{4'b0011, 1'b1, 1};
        fixed_tbl[5] = '{4'b0001, 1'b1, 0};
        rr_seq     = '{3, 2, 1, 0, 3, 2, 1, 0};
        sparse_seq = '{3, 0, 3, 0};

        rst_n = 1'b1;
        req   = 4'b0000;
        mode  = 1'b0;
        ack   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_grant("reset", 1'b0, 0);
        chk("reset.ptr", int'(dut.ptr), 3);
        step();
        step();
        rst_n = 1'b1;

        // Fixed-priority truth table, ack held so every edge reloads.
        ack  = 1'b1;
        mode = 1'b0;
        foreach (fixed_tbl[t]) begin
            req = fixed_tbl[t].r;
            if (t == 1) begin
                #1;
                chk("latency.pre_edge_valid", int'(valid), 0);
            end
            step();
            chk_grant($sformatf("fixed[%0d]", t), fixed_tbl[t].v, fixed_tbl[t].i);
        end

        // Hold: grant must survive req changes until ack.
        req = 4'b0000;
        step();
        chk_grant("hold.drain", 1'b0, 0);
        ack = 1'b0;
        req = 4'b1010;
        step();
        chk_grant("hold.load", 1'b1, 3);
        req = 4'b0001;
        step();
        chk_grant("hold.stable", 1'b1, 3);
        mode = 1'b1;
        step();
        chk_grant("hold.mode_change", 1'b1, 3);
        mode = 1'b0;
        ack  = 1'b1;
        step();
        chk_grant("hold.release", 1'b1, 0);

        // Reset while a grant of index 2 is held.
        req = 4'b0100;
        step();
        chk_grant("mid.pre", 1'b1, 2);
        ack = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk_grant("mid.async_reset", 1'b0, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("mid.ptr_after_release", int'(dut.ptr), 3);

        // Round-robin fairness over all channels.
        mode = 1'b1;
        req  = 4'b1111;
        ack  = 1'b1;
        foreach (rr_seq[t]) begin
            step();
            chk_grant($sformatf("rr[%0d]", t), 1'b1, rr_seq[t]);
        end

        // Sparse round-robin, then fall back to fixed priority.
        req = 4'b1001;
        foreach (sparse_seq[t]) begin
            step();
            chk_grant($sformatf("sparse[%0d]", t), 1'b1, sparse_seq[t]);
        end
        mode = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            chk_grant($sformatf("sparse_fixed[%0d]", t), 1'b1, 3);
        end

        // Drain: accept grant 3 while req drops to zero; ptr moves to 2.
        req = 4'b0000;
        step();
        chk_grant("drain", 1'b0, 0);
        chk("drain.ptr", int'(dut.ptr), 2);
        mode = 1'b1;
        req  = 4'b1111;
        step();
        chk_grant("drain.next_rr", 1'b1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
